// File: rtl/hazard_ctrl.sv
// Scoreboard-based RAW hazard control for an in-order pipeline, plus wrong-path
// fetch discard after a taken branch and a stall-cycle performance counter.
module hazard_ctrl #(
  parameter int CNT_W       = 2,
  parameter int STALL_CNT_W = 32
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   id_valid,
  input  logic                   id_src1_en,
  input  logic                   id_src2_en,
  input  logic [4:0]             id_src1,
  input  logic [4:0]             id_src2,
  input  logic                   id_dest_we,
  input  logic [4:0]             id_dest,
  input  logic                   exe_allow_in,
  input  logic                   wb_valid,
  input  logic                   wb_we,
  input  logic [4:0]             wb_dest,
  input  logic                   exe_br_taken,
  input  logic                   if_req_outstanding,
  input  logic                   if_resp_valid,
  output logic                   id_stall,
  output logic                   id_ready_go,
  output logic                   br_taken_cancel,
  output logic                   if_resp_discard,
  output logic                   sb_busy,
  output logic                   sb_error,
  output logic [STALL_CNT_W-1:0] stall_cycles
);

  localparam logic [CNT_W-1:0] CNT_MAX = '1;
  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

  typedef enum logic {IDLE, WAIT_RESP} state_t;

  state_t           state, state_nxt;
  logic [CNT_W-1:0] cnt     [32];
  logic [CNT_W-1:0] cnt_nxt [32];
  logic [31:0]      inc, dec, busy_vec;
  logic             issue, src1_haz, src2_haz, hazard, err_hit, discard;

  always_comb begin
    for (int r = 0; r < 32; r++)
      dec[r] = wb_valid & wb_we & (wb_dest == 5'(r)) & (r != 0);
  end

  // A pending write that retires this very cycle is visible through the
  // write-through regfile, so it no longer blocks the reader.
  assign src1_haz = id_src1_en & (id_src1 != 5'd0) & (cnt[id_src1] != '0)
                  & ~((cnt[id_src1] == CNT_ONE) & dec[id_src1]);
  assign src2_haz = id_src2_en & (id_src2 != 5'd0) & (cnt[id_src2] != '0)
                  & ~((cnt[id_src2] == CNT_ONE) & dec[id_src2]);

  assign hazard          = id_valid & (src1_haz | src2_haz);
  assign id_stall        = hazard & ~reset;
  assign id_ready_go     = ~id_stall;
  assign br_taken_cancel = exe_br_taken;
  assign issue           = id_valid & ~id_stall & exe_allow_in & ~br_taken_cancel;

  always_comb begin
    for (int r = 0; r < 32; r++)
      inc[r] = issue & id_dest_we & (id_dest == 5'(r)) & (r != 0);
  end

  // Saturating counters: overflow/underflow hold the value and flag an error.
  always_comb begin
    err_hit = 1'b0;
    for (int r = 0; r < 32; r++) begin
      cnt_nxt[r] = cnt[r];
      if (inc[r] & ~dec[r]) begin
        if (cnt[r] == CNT_MAX) err_hit = 1'b1;
        else                   cnt_nxt[r] = cnt[r] + CNT_ONE;
      end else if (dec[r] & ~inc[r]) begin
        if (cnt[r] == '0) err_hit = 1'b1;
        else              cnt_nxt[r] = cnt[r] - CNT_ONE;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      for (int r = 0; r < 32; r++) cnt[r] <= '0;
      sb_error     <= 1'b0;
      stall_cycles <= '0;
    end else begin
      for (int r = 0; r < 32; r++) cnt[r] <= cnt_nxt[r];
      if (err_hit)  sb_error     <= 1'b1;
      if (id_stall) stall_cycles <= stall_cycles + STALL_CNT_W'(1);
    end
  end

  always_comb begin
    for (int r = 0; r < 32; r++) busy_vec[r] = (cnt[r] != '0);
  end

  assign sb_busy = (|busy_vec) & ~reset;

  always_ff @(posedge clk) begin
    if (reset) state <= IDLE;
    else       state <= state_nxt;
  end

  // After a taken branch the next returning fetch belongs to the wrong path.
  always_comb begin
    state_nxt = state;
    discard   = 1'b0;
    case (state)
      IDLE: begin
        if (exe_br_taken & if_resp_valid)
          discard = 1'b1;
        else if (exe_br_taken & if_req_outstanding)
          state_nxt = WAIT_RESP;
      end
      WAIT_RESP: begin
        discard = if_resp_valid;
        if (if_resp_valid) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  assign if_resp_discard = discard & ~reset;

endmodule

// File: doc/hazard_ctrl.md
HAZARD_CTRL -- requirements
Module: hazard_ctrl

Interface
REQ-001 SHALL have parameter CNT_W, default 2: width of each per-register pending-write counter.
REQ-002 SHALL have parameter STALL_CNT_W, default 32: width of the stall-cycle performance counter.
REQ-003 SHALL have port clk  input  1  single clock; all state updates on its rising edge.
REQ-004 SHALL have port reset  input  1  synchronous, active-high reset.
REQ-005 SHALL have ports id_valid  input  1  ID holds a valid instruction; id_src1_en, id_src2_en  input  1 each  source reads enabled; id_src1, id_src2  input  5 each  source register numbers.
REQ-006 SHALL have ports id_dest_we  input  1  ID instruction writes a GPR; id_dest  input  5  destination register number.
REQ-007 SHALL have port exe_allow_in  input  1  EXE can accept an instruction this cycle.
REQ-008 SHALL have ports wb_valid, wb_we  input  1 each; wb_dest  input  5  WB retirement write.
REQ-009 SHALL have port exe_br_taken  input  1  valid-qualified taken branch/jump resolved in EXE.
REQ-010 SHALL have ports if_req_outstanding  input  1  an instruction fetch is in flight; if_resp_valid  input  1  fetch data returns this cycle.
REQ-011 SHALL have outputs id_stall  1; id_ready_go  1; br_taken_cancel  1; if_resp_discard  1; sb_busy  1; sb_error  1; stall_cycles  STALL_CNT_W.

Function
REQ-012 SHALL keep 32 counters cnt[0..31] of CNT_W bits; cnt[0] SHALL stay 0 permanently.
REQ-013 SHALL define issue = id_valid & ~id_stall & exe_allow_in & ~br_taken_cancel.
REQ-014 SHALL define inc[r] = issue & id_dest_we & (id_dest==r) & (r!=0), and dec[r] = wb_valid & wb_we & (wb_dest==r) & (r!=0).
REQ-015 SHALL next-state each counter: inc&~dec -> +1; dec&~inc -> -1; both or neither -> unchanged.
REQ-016 SHALL, on inc with counter at all-ones, hold the counter and set sticky sb_error; on dec with counter 0, hold 0 and set sb_error.
REQ-017 SHALL treat a source as hazarded when enabled, nonzero, cnt!=0, and NOT (cnt==1 & dec on that register this cycle) (regfile is write-through).
REQ-018 SHALL drive id_stall = id_valid & (src1 hazarded | src2 hazarded), combinationally; id_ready_go = ~id_stall.
REQ-019 SHALL drive br_taken_cancel = exe_br_taken, combinationally, in the same cycle only.
REQ-020 SHALL implement FSM IDLE/WAIT_RESP for wrong-path fetch discard.
REQ-021 IDLE: exe_br_taken & if_resp_valid -> if_resp_discard=1 that cycle, stay IDLE; exe_br_taken & if_req_outstanding & ~if_resp_valid -> WAIT_RESP; else stay.
REQ-022 WAIT_RESP: if_resp_discard = if_resp_valid; if_resp_valid -> IDLE; further exe_br_taken -> stay WAIT_RESP.
REQ-023 SHALL drive if_resp_discard=0 in IDLE except per REQ-021.
REQ-024 SHALL drive sb_busy = OR of all counters nonzero (registered state).
REQ-025 SHALL increment stall_cycles by 1 in every cycle id_stall=1, wrapping modulo 2^STALL_CNT_W.

Reset
REQ-026 SHALL, when reset=1 at a clock edge, clear all counters, sb_error, stall_cycles and force IDLE, overriding any simultaneous inc/dec/branch.
REQ-027 SHALL, during reset and the following cycle with no activity, present id_stall=0, sb_busy=0, sb_error=0, if_resp_discard=0, stall_cycles=0.

Verification
REQ-028 RAW: issue write r5, next cycle ID reads r5 -> id_stall=1 until WB retires r5; retire cycle id_stall=0; stall_cycles equals stalled cycles.
REQ-029 Same-cycle inc/dec: issue write r7 while WB retires r7 with cnt[7]=1 -> cnt[7] stays 1, sb_busy=1, no sb_error.
REQ-030 Register 0: issue write r0, read r0 next cycle -> no stall, sb_busy=0.
REQ-031 Branch with fetch in flight: exe_br_taken=1, if_req_outstanding=1, if_resp_valid=0 -> br_taken_cancel=1 one cycle, WAIT_RESP; response 3 cycles later -> if_resp_discard=1 that cycle, back to IDLE.
REQ-032 Overflow: three issues to r3 without retire, fourth issue -> cnt[3]=3, sb_error=1 sticky; reset -> sb_error=0, cnt[3]=0.
REQ-033 Branch blocks issue: id_valid=1, exe_allow_in=1, exe_br_taken=1, id_dest_we=1, id_dest=9 -> cnt[9] unchanged.
